// File: rtl/stc_pkg.sv
// Shared widths, constants and FSM state type for the STC / CFAR video chain.
package stc_pkg;

  localparam int unsigned VID_W   = 12;
  localparam int unsigned RANGE_W = 12;
  localparam int unsigned THR_W   = 18;

  localparam logic [RANGE_W-1:0] SAMPLE_LIMIT = 12'd2626;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } cfar_state_t;

endpackage

// File: rtl/cfar_window.sv
// W-deep video shift register for the CFAR sliding window.
// Position 0 holds the newest sample, position W-1 the oldest.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_clr           synchronous clear; a same-cycle i_load lands in position 0
//   i_load          shift in i_din
//   i_din           entering video sample
//   o_lead_in       sample entering the lead side (the input itself)
//   o_lead_out      sample leaving the lead side into the guard cells
//   o_cut           cell under test (position H)
//   o_lag_in        sample entering the lag side from the guard cells
//   o_lag_out       sample leaving the lag side (oldest cell)
module cfar_window
  import stc_pkg::*;
#(
  parameter int unsigned WIDTH       = VID_W,
  parameter int unsigned REF_CELLS   = 8,
  parameter int unsigned GUARD_CELLS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_lead_in,
  output logic [WIDTH-1:0] o_lead_out,
  output logic [WIDTH-1:0] o_cut,
  output logic [WIDTH-1:0] o_lag_in,
  output logic [WIDTH-1:0] o_lag_out
);

  localparam int unsigned H = REF_CELLS + GUARD_CELLS;
  localparam int unsigned W = 2 * H + 1;

  logic [WIDTH-1:0] r_win [W];

  // Shift register with clear; clear plus load starts a fresh window with one sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(W); i++) r_win[i] <= '0;
    end else if (i_clr) begin
      for (int i = 1; i < int'(W); i++) r_win[i] <= '0;
      r_win[0] <= i_load ? i_din : '0;
    end else if (i_load) begin
      r_win[0] <= i_din;
      for (int i = 1; i < int'(W); i++) r_win[i] <= r_win[i-1];
    end
  end

  assign o_lead_in  = i_din;
  assign o_lead_out = r_win[REF_CELLS-1];
  assign o_cut      = r_win[H];
  assign o_lag_in   = r_win[W-REF_CELLS-1];
  assign o_lag_out  = r_win[W-1];

endmodule

// File: rtl/cfar_detector.sv
// Cell-averaging CFAR detector fed by the STC stage.
// Stage 1: window shift plus incremental lag/lead sum update.
// Stage 2: mean, scaled threshold with floor, strict compare; outputs registered.
// Build option: define CFAR_GO_EN for greatest-of CFAR (mean from the larger side).
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   trig         radar trigger, restarts the sweep (wins over vid_valid)
//   vid_valid    vid_in valid, one sample accepted per high cycle
//   vid_in       12-bit STC-compensated video
//   det_valid    det/cut_vid/cut_range valid
//   det          CUT exceeded the threshold
//   cut_vid      video of the CUT
//   cut_range    sample index of the CUT within the sweep
module cfar_detector
  import stc_pkg::*;
#(
  parameter int unsigned REF_CELLS   = 8,
  parameter int unsigned GUARD_CELLS = 2,
  parameter int unsigned SCALE       = 12,
  parameter int unsigned MIN_THRESH  = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trig,
  input  logic               vid_valid,
  input  logic [VID_W-1:0]   vid_in,
  output logic               det_valid,
  output logic               det,
  output logic [VID_W-1:0]   cut_vid,
  output logic [RANGE_W-1:0] cut_range
);

  localparam int unsigned H      = REF_CELLS + GUARD_CELLS;
  localparam int unsigned W      = 2 * H + 1;
  localparam int unsigned LOG_R  = $clog2(REF_CELLS);
  localparam int unsigned SUM_W  = VID_W + LOG_R;
  localparam int unsigned FILL_W = $clog2(W + 1);

  localparam logic [5:0]       SCALE_Q = 6'(SCALE);
  localparam logic [THR_W-1:0] THR_MIN = THR_W'(MIN_THRESH);

  cfar_state_t r_state, w_state_next;

  logic               w_accept;
  logic [FILL_W-1:0]  r_fill, w_fill_next;
  logic [RANGE_W-1:0] r_range, w_idx;
  logic [SUM_W-1:0]   r_lag_sum, r_lead_sum, w_lag_next, w_lead_next;
  logic               r_s1_valid;
  logic [RANGE_W-1:0] r_s1_range;

  logic [VID_W-1:0] w_lead_in, w_lead_out, w_cut, w_lag_in, w_lag_out;

  logic [VID_W-1:0] w_mean;
  logic [THR_W-1:0] w_prod, w_scaled, w_thr;
  logic             w_det;

  logic               r_det_valid, r_det;
  logic [VID_W-1:0]   r_cut_vid;
  logic [RANGE_W-1:0] r_cut_range;

  // Samples are ignored in IDLE unless the same cycle carries the trigger.
  assign w_accept = vid_valid && ((r_state != IDLE) || trig);
  assign w_idx    = trig ? '0 : r_range;

  cfar_window #(
    .WIDTH       (VID_W),
    .REF_CELLS   (REF_CELLS),
    .GUARD_CELLS (GUARD_CELLS)
  ) u_window (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (trig),
    .i_load     (w_accept),
    .i_din      (vid_in),
    .o_lead_in  (w_lead_in),
    .o_lead_out (w_lead_out),
    .o_cut      (w_cut),
    .o_lag_in   (w_lag_in),
    .o_lag_out  (w_lag_out)
  );

  // Fill count and incremental sums; modulo arithmetic keeps the final sum exact.
  always_comb begin
    w_fill_next = r_fill;
    w_lag_next  = r_lag_sum;
    w_lead_next = r_lead_sum;
    if (trig) begin
      w_fill_next = vid_valid ? FILL_W'(1) : '0;
      w_lag_next  = '0;
      w_lead_next = vid_valid ? SUM_W'(vid_in) : '0;
    end else if (w_accept) begin
      if (r_fill != FILL_W'(W)) w_fill_next = r_fill + FILL_W'(1);
      w_lead_next = r_lead_sum + SUM_W'(w_lead_in) - SUM_W'(w_lead_out);
      w_lag_next  = r_lag_sum + SUM_W'(w_lag_in) - SUM_W'(w_lag_out);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // FSM next state.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (trig) w_state_next = FILL;
      FILL: begin
        if (trig)                               w_state_next = FILL;
        else if (w_fill_next == FILL_W'(W))     w_state_next = RUN;
      end
      RUN:     if (trig) w_state_next = FILL;
      default: w_state_next = IDLE;
    endcase
  end

  // Stage 1: counters, sums, and the tag for the CUT now centred in the window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill     <= '0;
      r_range    <= '0;
      r_lag_sum  <= '0;
      r_lead_sum <= '0;
      r_s1_valid <= 1'b0;
      r_s1_range <= '0;
    end else begin
      r_fill     <= w_fill_next;
      r_lag_sum  <= w_lag_next;
      r_lead_sum <= w_lead_next;
      r_s1_valid <= w_accept && (w_fill_next == FILL_W'(W));
      if (w_accept) begin
        r_range    <= (w_idx == '1) ? w_idx : w_idx + RANGE_W'(1);
        r_s1_range <= w_idx - RANGE_W'(H);
      end else if (trig) begin
        r_range <= '0;
      end
    end
  end

  // Local mean of the reference cells.
`ifdef CFAR_GO_EN
  assign w_mean = VID_W'(((r_lag_sum > r_lead_sum) ? r_lag_sum : r_lead_sum) >> LOG_R);
`else
  logic [SUM_W:0] w_pair;
  assign w_pair = {1'b0, r_lag_sum} + {1'b0, r_lead_sum};
  assign w_mean = VID_W'(w_pair >> (LOG_R + 1));
`endif

  // Threshold alpha*mean in Q4.2 with a floor, then strict compare.
  assign w_prod   = THR_W'(w_mean) * THR_W'(SCALE_Q);
  assign w_scaled = w_prod >> 2;
  assign w_thr    = (w_scaled > THR_MIN) ? w_scaled : THR_MIN;
  assign w_det    = THR_W'(w_cut) > w_thr;

  // Stage 2: result registers; data fields hold across empty cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_det_valid <= 1'b0;
      r_det       <= 1'b0;
      r_cut_vid   <= '0;
      r_cut_range <= '0;
    end else begin
      r_det_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_det       <= w_det;
        r_cut_vid   <= w_cut;
        r_cut_range <= r_s1_range;
      end
    end
  end

  assign det_valid = r_det_valid;
  assign det       = r_det;
  assign cut_vid   = r_cut_vid;
  assign cut_range = r_cut_range;

endmodule

// File: tb/tb_cfar_detector.sv
// Directed bench for cfar_detector with default parameters (H=10, W=21).
module tb_cfar_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic        vid_valid;
  logic [11:0] vid_in;
  logic        det_valid;
  logic        det;
  logic [11:0] cut_vid;
  logic [11:0] cut_range;

  int n_checks = 0;
  int n_fail   = 0;

  int step_n, n_valid, n_det, first_range, first_step, last_range, det_range, det_vid;

  always #5 clk = ~clk;

  cfar_detector dut (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .vid_valid (vid_valid),
    .vid_in    (vid_in),
    .det_valid (det_valid),
    .det       (det),
    .cut_vid   (cut_vid),
    .cut_range (cut_range)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    step_n = 0; n_valid = 0; n_det = 0;
    first_range = -1; first_step = -1; last_range = -1;
    det_range = -1; det_vid = -1;
  endtask

  // Drive one cycle, then sample outputs 1 time unit after the edge.
  task automatic step(input logic t, input logic v, input int x);
    trig = t; vid_valid = v; vid_in = 12'(x);
    @(posedge clk); #1;
    step_n++;
    if (det_valid === 1'b1) begin
      n_valid++;
      if (first_range < 0) begin
        first_range = int'(cut_range);
        first_step  = step_n;
      end
      last_range = int'(cut_range);
      if (det === 1'b1) begin
        n_det++;
        det_range = int'(cut_range);
        det_vid   = int'(cut_vid);
      end
    end
  endtask

  task automatic flush();
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
  endtask

  // Full sweep: base level, optional clutter edge and a single spike.
  task automatic sweep(input int n, input int base, input int edge_idx, input int edge_val,
                       input int spike_idx, input int spike_val);
    int v;
    clear_log();
    for (int i = 0; i < n; i++) begin
      v = (i >= edge_idx) ? edge_val : base;
      if (i == spike_idx) v = spike_val;
      step(i == 0, 1'b1, v);
    end
    flush();
  endtask

  initial begin
    rst = 1'b0; trig = 1'b0; vid_valid = 1'b0; vid_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_det_valid", 32'(det_valid), 0);
    check("reset_det",       32'(det), 0);
    check("reset_cut_vid",   32'(cut_vid), 0);
    check("reset_cut_range", 32'(cut_range), 0);
    #4 rst = 1'b1;
    @(posedge clk); #1;

    // 1: flat 100 with a bubble after sample 49
    clear_log();
    step(1'b1, 1'b1, 100);
    for (int i = 1; i < 50; i++) step(1'b0, 1'b1, 100);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b1, 100);
    check("bubble_det_valid",  32'(det_valid), 0);
    check("bubble_range_hold", 32'(cut_range), 39);
    for (int i = 51; i < 100; i++) step(1'b0, 1'b1, 100);
    flush();
    check("flat_n_valid",     n_valid, 80);
    check("flat_n_det",       n_det, 0);
    check("flat_first_range", first_range, 10);
    check("flat_first_step",  first_step, 22);
    check("flat_last_range",  last_range, 89);

    // 2: spike 400 over 100 detects at 50 (thr 300); 300 does not
    sweep(100, 100, 9999, 0, 50, 400);
    check("spike400_n_det", n_det, 1);
    check("spike400_range", det_range, 50);
    check("spike400_vid",   det_vid, 400);
    sweep(100, 100, 9999, 0, 50, 300);
    check("spike300_n_det", n_det, 0);

    // 3: zero background, threshold floor 64
    sweep(60, 0, 9999, 0, 30, 65);
    check("floor65_n_det", n_det, 1);
    check("floor65_range", det_range, 30);
    sweep(60, 0, 9999, 0, 30, 64);
    check("floor64_n_det", n_det, 0);

    // 4: retrigger with a sample in the same cycle
    clear_log();
    step(1'b1, 1'b1, 100);
    for (int i = 1; i < 40; i++) step(1'b0, 1'b1, 100);
    step(1'b1, 1'b1, 100);
    check("retrig_old_valid", 32'(det_valid), 1);
    check("retrig_old_range", 32'(cut_range), 29);
    clear_log();
    step(1'b0, 1'b1, 100);
    check("retrig_new_quiet", 32'(det_valid), 0);
    for (int j = 2; j < 30; j++) step(1'b0, 1'b1, 100);
    flush();
    check("retrig_first_step",  first_step, 21);
    check("retrig_first_range", first_range, 10);
    check("retrig_n_valid",     n_valid, 10);

    // 5: clutter step to 1000 at 60, target 2500 at 63
    sweep(90, 100, 60, 1000, 63, 2500);
`ifdef CFAR_GO_EN
    check("clutter_n_det", n_det, 0);
`else
    check("clutter_n_det", n_det, 1);
    check("clutter_range", det_range, 63);
`endif

    // 6: reset mid-sweep, then samples without a trigger
    clear_log();
    for (int i = 0; i < 30; i++) step(i == 0, 1'b1, 100);
    check("prerst_det_valid", 32'(det_valid), 1);
    #1 rst = 1'b0;
    #1;
    check("rst_det_valid", 32'(det_valid), 0);
    check("rst_det",       32'(det), 0);
    check("rst_cut_vid",   32'(cut_vid), 0);
    check("rst_cut_range", 32'(cut_range), 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    clear_log();
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 100);
    flush();
    check("idle_n_valid", n_valid, 0);
    check("idle_cut_vid", 32'(cut_vid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
